// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM state type and flag bit positions shared by the
// alu_seq design files and its bench.
package alu_seq_pkg;

    // Opcodes carried over from the single-cycle datapath ALU
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_NOR   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1010;
    // Opcodes added with the sequential version
    localparam logic [3:0] OP_SLTU  = 4'b1011;
    localparam logic [3:0] OP_MUL   = 4'b1100;
    localparam logic [3:0] OP_MULHU = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_REMU  = 4'b1111;

    // Bit positions inside the 4-bit flags word
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_seq_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle of the sequential ALU.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. The
// requester holds a, b and ctrl stable while in_valid is high and in_ready is
// low; the ALU holds res and flags stable while out_valid is high and
// out_ready is low. state mirrors the internal FSM for observation only.
interface alu_seq_if
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic [3:0]       flags;
    logic             busy;
    alu_seq_state_e   state;

    // Control unit side
    modport master (
        output in_valid, a, b, ctrl, out_ready,
        input  in_ready, out_valid, res, flags, busy, state
    );

    // ALU side
    modport slave (
        input  in_valid, a, b, ctrl, out_ready,
        output in_ready, out_valid, res, flags, busy, state
    );
endinterface

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: shared iterative datapath. A 2*WIDTH shift register (hi:lo)
// plus one WIDTH+1-bit adder/subtractor perform one radix-2 shift-add
// multiply step or one restoring-division step per enabled cycle.
// After WIDTH steps: multiply -> hi:lo is the product;
//                    divide   -> lo is the quotient, hi the remainder.
// The divide step only exists when ALU_SEQ_DIV_EN is defined.
module alu_seq_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic [WIDTH-1:0] hi_q, lo_q, addend_q;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [WIDTH:0]   x, y, sum;
    logic             sub;

`ifdef ALU_SEQ_DIV_EN
    logic div_q;
`else
    logic unused_op_div;
    assign unused_op_div = op_div;
`endif

    // One step of the selected algorithm through the shared adder
    always_comb begin
        x    = {1'b0, hi_q};
        y    = lo_q[0] ? {1'b0, addend_q} : '0;
        sub  = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        if (div_q) begin
            // trial subtract of the divisor from the shifted partial remainder
            x   = {hi_q, lo_q[WIDTH-1]};
            y   = {1'b0, addend_q};
            sub = 1'b1;
        end
`endif
        sum  = x + (sub ? ~y : y) + {{WIDTH{1'b0}}, sub};
        hi_d = sum[WIDTH:1];
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
        if (div_q) begin
            // partial remainder < divisor keeps the difference inside WIDTH+1 bits,
            // so its sign bit alone tells whether the subtraction succeeded
            hi_d = sum[WIDTH] ? x[WIDTH-1:0] : sum[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ~sum[WIDTH]};
        end
`endif
    end

    // Load operands on start, advance one step per enabled cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            addend_q <= '0;
`ifdef ALU_SEQ_DIV_EN
            div_q    <= 1'b0;
`endif
        end else if (start) begin
            hi_q     <= '0;
`ifdef ALU_SEQ_DIV_EN
            div_q    <= op_div;
            lo_q     <= op_div ? a : b;
            addend_q <= op_div ? b : a;
`else
            lo_q     <= b;
            addend_q <= a;
`endif
        end else if (step) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU for the multi-cycle datapath. Single-cycle ops
// (add/sub/logic/slt/sltu) finish the cycle after accept; mul/mulhu (and
// divu/remu when ALU_SEQ_DIV_EN is defined) run WIDTH steps in alu_seq_iter.
// Without ALU_SEQ_DIV_EN, divu/remu finish at once with res 0, flags 0101.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    alu_seq_state_e   state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       flags_q;
    logic             from_iter_q, sel_hi_q;
    logic             accept, iter_op;
    logic [WIDTH-1:0] iter_hi, iter_lo, iter_res;

    logic             sub_op, arith, unsup, ovf;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_res;
    logic [3:0]       sc_flags;

    assign bus.in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Decide whether the offered opcode needs the iterative datapath
    always_comb begin
        iter_op = 1'b0;
        case (bus.ctrl)
            OP_MUL, OP_MULHU: iter_op = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            OP_DIVU, OP_REMU: iter_op = (bus.b != '0);
`endif
            default: iter_op = 1'b0;
        endcase
    end

    // Single-cycle ALU: one adder shared by add/sub/slt/sltu, plus logic ops
    always_comb begin
        sub_op = (bus.ctrl == OP_SUB) || (bus.ctrl == OP_SLT) || (bus.ctrl == OP_SLTU);
        b_eff  = sub_op ? ~bus.b : bus.b;
        sum    = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
        ovf    = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
        sc_res = '0;
        arith  = 1'b0;
        unsup  = 1'b0;
        case (bus.ctrl)
            OP_ADD, OP_SUB: begin sc_res = sum[WIDTH-1:0]; arith = 1'b1; end
            OP_AND:  sc_res = bus.a & bus.b;
            OP_OR:   sc_res = bus.a | bus.b;
            OP_XOR:  sc_res = bus.a ^ bus.b;
            OP_NOR:  sc_res = ~(bus.a | bus.b);
            OP_SLT:  begin sc_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf}; arith = 1'b1; end
            OP_SLTU: begin sc_res = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};       arith = 1'b1; end
`ifdef ALU_SEQ_DIV_EN
            // only reached with b == 0; nonzero divisors go to the iterator
            OP_DIVU: sc_res = '1;
            OP_REMU: sc_res = bus.a;
`else
            OP_DIVU, OP_REMU: unsup = 1'b1;
`endif
            default: sc_res = '0;
        endcase
        sc_flags        = '0;
        sc_flags[FLG_N] = sc_res[WIDTH-1];
        sc_flags[FLG_Z] = (sc_res == '0);
        sc_flags[FLG_C] = arith & sum[WIDTH];
        sc_flags[FLG_V] = arith & ovf;
        if (unsup) sc_flags = 4'b0101;
    end

    // FSM next state: accept from IDLE or (back-to-back) from DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = iter_op ? BUSY : DONE;
            BUSY: if (count_q == '0) state_d = DONE;
            DONE: begin
                if (accept)             state_d = iter_op ? BUSY : DONE;
                else if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Iteration counter: WIDTH-1 down to 0 gives WIDTH busy cycles
    always_ff @(posedge clk) begin
        if (reset)                                  count_q <= '0;
        else if (accept)                            count_q <= CNT_W'(WIDTH - 1);
        else if (state_q == BUSY && count_q != '0)  count_q <= count_q - 1'b1;
    end

    // Result registers; iterative results are read straight from alu_seq_iter
    always_ff @(posedge clk) begin
        if (reset) begin
            res_q       <= '0;
            flags_q     <= '0;
            from_iter_q <= 1'b0;
            sel_hi_q    <= 1'b0;
        end else if (accept) begin
            from_iter_q <= iter_op;
            sel_hi_q    <= bus.ctrl[0];   // mulhu/remu use the high half
            if (!iter_op) begin
                res_q   <= sc_res;
                flags_q <= sc_flags;
            end
        end
    end

    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (accept && iter_op),
        .op_div (bus.ctrl[1]),
        .a      (bus.a),
        .b      (bus.b),
        .step   (state_q == BUSY),
        .hi     (iter_hi),
        .lo     (iter_lo)
    );

    assign iter_res      = sel_hi_q ? iter_hi : iter_lo;
    assign bus.res       = from_iter_q ? iter_res : res_q;
    assign bus.flags     = from_iter_q ? {iter_res[WIDTH-1], (iter_res == '0), 2'b00} : flags_q;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == BUSY);
    assign bus.state     = state_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor of the single-cycle datapath ALU. It keeps the existing add/sub/logic/slt opcodes and flag semantics and adds unsigned set-less-than, an iterative multiplier, and an optional iterative divider. The block sits between the register-read stage and writeback of the multi-cycle datapath, and uses valid/ready handshakes on both sides so the control unit can stall on long operations.

## Interface
- `WIDTH`, 32: operand/result width, must be ≥ 4.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `in_valid` input, 1 bit: operation request.
- `in_ready` output, 1 bit: block can accept a request this cycle.
- `a`, `b` input, WIDTH bits each: operands; sampled only on accept.
- `ctrl` input, 4 bits: opcode; sampled only on accept.
- `out_valid` output, 1 bit: `res`/`flags` hold a completed result.
- `out_ready` input, 1 bit: consumer takes the result.
- `res` output, WIDTH bits: registered result.
- `flags` output, 4 bits: bit 3 negative, bit 2 zero, bit 1 carry, bit 0 overflow.
- `busy` output, 1 bit: iterative operation in progress.

## Operation
- Accept occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- Opcodes:
  - Unchanged: 0000 add, 0010 sub, 0100 and, 0101 or, 0110 xor, 0111 nor, 1010 slt (signed).
  - New: 1011 sltu, 1100 mul (low WIDTH bits), 1101 mulhu (high WIDTH bits of the unsigned product), 1110 divu (quotient), 1111 remu (remainder).
  - Any other code gives `res` = 0.
- Flags:
  - add/sub/slt/sltu: n/z/c/v computed exactly as the single-cycle ALU. Carry is the adder carry-out, with sub = a + ~b + 1. Overflow is signed overflow of the adder.
  - Logic, mul and div ops: c = v = 0; n = `res[WIDTH-1]`; z = (`res` == 0).
- Iterative mul: radix-2 shift-add over a 2·WIDTH accumulator, one bit per cycle, WIDTH iterations.
- Iterative div: unsigned restoring division, one quotient bit per cycle, WIDTH iterations.
- Divide by zero: no iteration. divu gives all ones; remu gives `a`. Completes with single-cycle latency.
- FSM states:
  - IDLE: on accept of a single-cycle op or a div-by-zero, go to DONE; on accept of mul/div, go to BUSY and load count = WIDTH−1.
  - BUSY: step the datapath; count decrements; when count == 0, go to DONE with the result registered.
  - DONE: `out_valid` = 1. If `out_ready` and not `in_valid`, go to IDLE. If `out_ready` and `in_valid`, accept the new op in the same cycle (back-to-back), with the same transitions as from IDLE.
- `in_ready` = (state == IDLE) || (state == DONE && `out_ready`).
- `busy` = (state == BUSY).
- `res`/`flags` hold stable while `out_valid && !out_ready`.

## Timing
- Reset values: state IDLE, `res` 0, `flags` 0000, `out_valid` 0, `busy` 0. `in_ready` is 1 in the first cycle after reset.
- Reset is asserted mid-BUSY or in DONE: the operation is aborted and the result is dropped. No `out_valid` appears for it.
- Single-cycle op (or div-by-zero) accepted at edge k: `out_valid` is high from edge k+1.
- mul/mulhu/divu/remu accepted at edge k: `out_valid` is high from edge k+WIDTH.
- Sustained throughput with `out_ready` held high: one single-cycle op per clock.
- `in_valid` while `in_ready` = 0 is ignored. The requester must hold the request.

## Configuration
- `ALU_SEQ_DIV_EN` defined: the divider datapath and opcodes 1110/1111 are present, as described above.
- `ALU_SEQ_DIV_EN` undefined: no divider logic is built. 1110/1111 complete with single-cycle latency, `res` = 0, flags = 0101 (zero and overflow set, marking an unsupported op).

## Structure
- Package `alu_seq_pkg` holds:
  - opcode localparams (`OP_ADD` … `OP_REMU`);
  - the FSM state enum (IDLE/BUSY/DONE);
  - flag bit index constants (`FLG_N`, `FLG_Z`, `FLG_C`, `FLG_V`).
- Sub-module `alu_seq_iter` contains the shared shift register and WIDTH+1-bit adder/subtractor used for both mul and div steps. Its inputs are start, op, operands and step enable; its outputs are the product/quotient/remainder registers.
- The top level holds the FSM, the iteration counter, the single-cycle combinational ALU, and the output registers.

## Test plan
- Reset mid-mul:
  - Accept mul 7×9, assert `reset` at cycle 5.
  - Required: `out_valid` never rises; `res` = 0; `in_ready` = 1 the next cycle.
- Back-to-back add/sub with `out_ready` held at 1:
  - add 0x7FFFFFFF+1, then sub 5−5.
  - Required: first result 0x80000000 with flags 1001 at cycle k+1; second result 0 with flags 0110 at cycle k+2.
- mul/mulhu at WIDTH = 32:
  - 0xFFFFFFFF × 0xFFFFFFFF.
  - Required: mul gives 0x00000001; mulhu gives 0xFFFFFFFE; each arrives exactly 32 cycles after accept.
- Divide:
  - divu 100/7 gives 14; remu 100/7 gives 2.
  - divu 5/0 gives 0xFFFFFFFF and remu 5/0 gives 5, both with single-cycle latency.
- Backpressure:
  - Hold `out_ready` = 0 for 10 cycles after slt(−1, 1).
  - Required: `res` = 1 held stable, `in_ready` = 0, then one transfer when `out_ready` rises.
- Build without `ALU_SEQ_DIV_EN`:
  - Issue divu 100/7.
  - Required: `res` = 0, flags 0101, single-cycle latency.
